sequence_generator: RTL and testbench

SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

---
 rtl/sequence_generator.sv | 104 ++++++++++
 tb/tb_sequence_generator.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/sequence_generator.sv
// rtl/sequence_generator.sv - seeded one-hot sequence generator driving an external lfsr stage
// Each entry costs two cycles: CARREGA presents the state, CAPTURA takes the lfsr result.
module sequence_generator #(
  parameter int          DEPTH        = 16,
  parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iniciar,
  input  logic [15:0] semente,
  input  logic [4:0]  tamanho,
  output logic [15:0] lfsr_entrada,
  input  logic [15:0] lfsr_saida,
  output logic        ocupado,
  output logic        pronto,
  output logic        erro,
  output logic [4:0]  gerados,
  input  logic [3:0]  rd_addr,
  output logic [3:0]  rd_data
);

  localparam logic [4:0] MAX_LEN = 5'(DEPTH);

  typedef enum logic [1:0] {OCIOSO, CARREGA, CAPTURA, FIM} state_t;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [4:0]  tam_q, tam_d;
  logic [4:0]  gerados_q, gerados_d;
  logic        erro_q, erro_d;
  logic        mem_we;
  logic [3:0]  one_hot;
  logic [3:0]  mem_q [DEPTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= OCIOSO;
      lfsr_q    <= 16'h0000;
      tam_q     <= 5'd0;
      gerados_q <= 5'd0;
      erro_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      tam_q     <= tam_d;
      gerados_q <= gerados_d;
      erro_q    <= erro_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    tam_d     = tam_q;
    gerados_d = gerados_q;
    erro_d    = 1'b0;
    mem_we    = 1'b0;
    case (state_q)
      OCIOSO: begin
        if (iniciar) begin
          if (tamanho != 5'd0 && tamanho <= MAX_LEN) begin
            tam_d     = tamanho;
            lfsr_d    = (semente == 16'h0000) ? SEED_DEFAULT : semente;
            gerados_d = 5'd0;
            state_d   = CARREGA;
          end else begin
            erro_d = 1'b1;
          end
        end
      end
      CARREGA: state_d = CAPTURA;
      CAPTURA: begin
        lfsr_d    = lfsr_saida;
        mem_we    = 1'b1;
        gerados_d = gerados_q + 5'd1;
        state_d   = (gerados_d == tam_q) ? FIM : CARREGA;
      end
      FIM:     state_d = OCIOSO;
      default: state_d = OCIOSO;
    endcase
  end

  always_comb begin
    one_hot = 4'b0000;
    one_hot[lfsr_saida[1:0]] = 1'b1;
  end

  // Only the slot at the current gerados index is ever written, so older entries persist.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 4'b0000;
    end else if (mem_we) begin
      mem_q[gerados_q[3:0]] <= one_hot;
    end
  end

  assign lfsr_entrada = lfsr_q;
  assign ocupado      = (state_q != OCIOSO);
  assign pronto       = (state_q == FIM);
  assign erro         = erro_q;
  assign gerados      = gerados_q;
  assign rd_data      = mem_q[rd_addr];

endmodule

// File: tb/tb_sequence_generator.sv
// tb/tb_sequence_generator.sv - directed vector bench for sequence_generator
// The external lfsr stage is the 16-bit Fibonacci lfsr with taps 16,14,13,11.
module tb_sequence_generator;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        iniciar = 1'b0;
  logic [15:0] semente = 16'h0000;
  logic [4:0]  tamanho = 5'd0;
  logic [15:0] lfsr_entrada;
  logic [15:0] lfsr_saida;
  logic        ocupado, pronto, erro;
  logic [4:0]  gerados;
  logic [3:0]  rd_addr = 4'd0;
  logic [3:0]  rd_data;

  int checks = 0;
  int errors = 0;
  logic [3:0] shadow [16];

  typedef struct {
    logic [15:0] seed;
    logic [4:0]  len;
    logic        exp_err;
    logic [3:0]  exp_mem0;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  assign lfsr_saida = lfsr_step(lfsr_entrada);

  always #5 clock = ~clock;

  sequence_generator dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .semente(semente),
    .tamanho(tamanho), .lfsr_entrada(lfsr_entrada), .lfsr_saida(lfsr_saida),
    .ocupado(ocupado), .pronto(pronto), .erro(erro), .gerados(gerados),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_mem(input string name);
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      rd_addr = 4'(i);
      #1;
      check($sformatf("%s mem[%0d]", name, i), 32'(rd_data), 32'(shadow[i]));
    end
  endtask

  task automatic run_valid(input logic [15:0] seed, input logic [4:0] len, input logic poke);
    logic [15:0] st [17];
    int pronto_at = 0;
    int pulses = 0;
    st[0] = (seed == 16'h0000) ? 16'hACE1 : seed;
    for (int k = 0; k < int'(len); k++) begin
      st[k+1] = lfsr_step(st[k]);
      shadow[k] = 4'b0001 << st[k+1][1:0];
    end
    @(negedge clock);
    iniciar = 1'b1; semente = seed; tamanho = len;
    @(posedge clock);
    #1 iniciar = 1'b0;
    for (int c = 1; c <= 2 * int'(len) + 6; c++) begin
      @(negedge clock);
      if (poke && c == 3) begin
        iniciar = 1'b1; semente = 16'h5A5A; tamanho = 5'd2;
      end
      if (poke && c == 4) iniciar = 1'b0;
      if (c <= 2 * int'(len) && c[0])
        check($sformatf("lfsr_entrada step %0d", (c - 1) / 2), 32'(lfsr_entrada), 32'(st[(c - 1) / 2]));
      if (c == 1) check("ocupado in run", 32'(ocupado), 32'd1);
      if (pronto) begin
        pulses++;
        if (pronto_at == 0) pronto_at = c;
      end
    end
    check("pronto latency", pronto_at, 2 * int'(len) + 1);
    check("pronto pulses", pulses, 1);
    check("ocupado after run", 32'(ocupado), 32'd0);
    check("gerados after run", 32'(gerados), 32'(len));
    check_mem("run");
  endtask

  task automatic run_invalid(input logic [15:0] seed, input logic [4:0] len);
    logic [4:0] g0 = gerados;
    @(negedge clock);
    iniciar = 1'b1; semente = seed; tamanho = len;
    @(posedge clock);
    #1 iniciar = 1'b0;
    @(negedge clock);
    check("erro pulse", 32'(erro), 32'd1);
    check("ocupado on erro", 32'(ocupado), 32'd0);
    @(negedge clock);
    check("erro cleared", 32'(erro), 32'd0);
    check("ocupado stays low", 32'(ocupado), 32'd0);
    check("gerados unchanged", 32'(gerados), 32'(g0));
    check_mem("invalid");
  endtask

  initial begin
    vecs[0] = '{16'h0003, 5'd3,  1'b0, 4'b0010};
    vecs[1] = '{16'h0000, 5'd1,  1'b0, 4'b0001};
    vecs[2] = '{16'h0003, 5'd0,  1'b1, 4'b0001};
    vecs[3] = '{16'h0003, 5'd17, 1'b1, 4'b0001};
    vecs[4] = '{16'hFFFF, 5'd2,  1'b0, 4'b1000};
    vecs[5] = '{16'h0001, 5'd31, 1'b1, 4'b1000};
    for (int i = 0; i < 16; i++) shadow[i] = 4'b0000;

    #1;
    check("reset lfsr_entrada", 32'(lfsr_entrada), 32'h0);
    check("reset ocupado", 32'(ocupado), 32'd0);
    check("reset pronto", 32'(pronto), 32'd0);
    check("reset erro", 32'(erro), 32'd0);
    check("reset gerados", 32'(gerados), 32'd0);
    check_mem("reset");
    @(negedge clock);
    reset = 1'b0;

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].exp_err) run_invalid(vecs[v].seed, vecs[v].len);
      else run_valid(vecs[v].seed, vecs[v].len, 1'b0);
      @(negedge clock);
      rd_addr = 4'd0;
      #1 check($sformatf("vec %0d mem0", v), 32'(rd_data), 32'(vecs[v].exp_mem0));
    end

    run_valid(16'h0003, 5'd3, 1'b1);
    run_valid(16'h1234, 5'd16, 1'b0);
    for (int i = 0; i < 16; i++) check($sformatf("one-hot %0d", i), 32'($onehot(shadow[i])), 32'd1);

    // Abort a 16-entry run in its second CAPTURA cycle.
    @(negedge clock);
    iniciar = 1'b1; semente = 16'hBEEF; tamanho = 5'd16;
    @(posedge clock);
    #1 iniciar = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) shadow[i] = 4'b0000;
    check("abort lfsr_entrada", 32'(lfsr_entrada), 32'h0);
    check("abort ocupado", 32'(ocupado), 32'd0);
    check("abort pronto", 32'(pronto), 32'd0);
    check("abort gerados", 32'(gerados), 32'd0);
    check_mem("abort");
    @(negedge clock);
    reset = 1'b0;
    begin
      int seen = 0;
      repeat (40) begin
        @(negedge clock);
        if (pronto || ocupado) seen++;
      end
      check("no pronto after abort", seen, 0);
    end
    run_valid(16'hBEEF, 5'd16, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
